// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the CPU core: debounces the single key into
// short/long press events and gates the CPU clock enable and reset from them.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned W_PC            = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic            key,
    input  logic [W_PC-1:0] cpu_pc,
    input  logic            brk_en,
    input  logic [W_PC-1:0] brk_pc,
    output logic            cpu_clk_en,
    output logic            cpu_rst,
    output logic [2:0]      state,
    output logic            halted,
    output logic [15:0]     step_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LP_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_RUN        = 3'd1,
        ST_PAUSE      = 3'd2,
        ST_STEP       = 3'd3,
        ST_HALT       = 3'd4
    } state_e;

    logic            key_meta_q;
    logic            key_sync_q;
    logic            key_db_q;
    logic            key_db_d;
    logic            key_db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic [LP_W-1:0] press_cnt_q;
    logic [LP_W-1:0] press_cnt_d;
    logic            long_press_s;
    logic            short_press_s;
    logic            brk_hit_s;

    state_e          state_q;
    logic [RC_W-1:0] rst_cnt_q;
    logic            cpu_clk_en_q;
    logic            cpu_rst_q;
    logic            halted_q;
    logic [15:0]     step_count_q;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (key_sync_q != key_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db_d = ~key_db_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Press length counter, saturating so a long hold cannot wrap into a short press.
    always_comb begin
        press_cnt_d = '0;
        if (key_db_q) begin
            if (press_cnt_q != LP_W'(LONG_CYCLES)) begin
                press_cnt_d = press_cnt_q + 1'b1;
            end else begin
                press_cnt_d = press_cnt_q;
            end
        end else begin
            press_cnt_d = '0;
        end
    end

    // press_cnt_q still holds the full press length in the cycle after the falling edge.
    assign long_press_s  = key_db_q && (press_cnt_q == LP_W'(LONG_CYCLES - 1));
    assign short_press_s = key_db_prev_q && !key_db_q && (press_cnt_q < LP_W'(LONG_CYCLES));
    assign brk_hit_s     = strobe && brk_en && (cpu_pc == brk_pc);

    // Key synchronizer, debouncer and press-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q    <= 1'b0;
            key_sync_q    <= 1'b0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            press_cnt_q   <= '0;
        end else begin
            key_meta_q    <= key;
            key_sync_q    <= key_meta_q;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            db_cnt_q      <= db_cnt_d;
            press_cnt_q   <= press_cnt_d;
        end
    end

    // Run-control FSM with registered enable, reset, halt flag and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET_HOLD;
            rst_cnt_q    <= '0;
            cpu_clk_en_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            halted_q     <= 1'b0;
            step_count_q <= 16'h0000;
        end else begin
            cpu_clk_en_q <= 1'b0;
            cpu_rst_q    <= 1'b0;
            halted_q     <= 1'b0;
            case (state_q)
                ST_RESET_HOLD: begin
                    cpu_rst_q    <= 1'b1;
                    step_count_q <= 16'h0000;
                    if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        rst_cnt_q <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A breakpoint outranks a coincident key event so brk_pc never executes.
                    if (brk_hit_s) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (short_press_s || long_press_s) begin
                        state_q <= ST_PAUSE;
                    end else if (strobe) begin
                        cpu_clk_en_q <= 1'b1;
                        step_count_q <= step_count_q + 16'h0001;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (short_press_s) begin
                        state_q      <= ST_STEP;
                        cpu_clk_en_q <= 1'b1;
                        step_count_q <= step_count_q + 16'h0001;
                    end else if (long_press_s) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_PAUSE;
                end
                ST_HALT: begin
                    if (long_press_s) begin
                        state_q      <= ST_RESET_HOLD;
                        cpu_rst_q    <= 1'b1;
                        rst_cnt_q    <= '0;
                        step_count_q <= 16'h0000;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_RESET_HOLD;
                    cpu_rst_q    <= 1'b1;
                    rst_cnt_q    <= '0;
                    step_count_q <= 16'h0000;
                end
            endcase
        end
    end

    assign cpu_clk_en = cpu_clk_en_q;
    assign cpu_rst    = cpu_rst_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed sequences, a vector table and a
// randomized run against a cycle-level behavioural model.
module tb_cpu_run_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int RSTC = 8;

    logic        clk;
    logic        rst_n;
    logic        strobe;
    logic        key;
    logic [31:0] cpu_pc;
    logic        brk_en;
    logic [31:0] brk_pc;
    logic        cpu_clk_en;
    logic        cpu_rst;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] step_count;

    int n_checks;
    int n_pass;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .RESET_CYCLES   (RSTC),
        .W_PC           (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe    (strobe),
        .key       (key),
        .cpu_pc    (cpu_pc),
        .brk_en    (brk_en),
        .brk_pc    (brk_pc),
        .cpu_clk_en(cpu_clk_en),
        .cpu_rst   (cpu_rst),
        .state     (state),
        .halted    (halted),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic        ben;
        logic [31:0] pc;
        logic        exp_en;
        logic [2:0]  exp_state;
        logic        exp_halt;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int bound, output int n);
        n = 0;
        while (state !== s && n < bound) begin
            tick();
            n++;
        end
        check(name, state, s);
    endtask

    // Behavioural model: mode codes 0 hold, 1 run, 2 pause, 3 step, 4 halt.
    int m_k1, m_k2, m_db, m_prev, m_run, m_hold;
    int m_mode, m_rc, m_en, m_rst, m_halt, m_cnt;

    task automatic model_reset();
        m_k1 = 0; m_k2 = 0; m_db = 0; m_prev = 0; m_run = 0; m_hold = 0;
        m_mode = 0; m_rc = 0; m_en = 0; m_rst = 1; m_halt = 0; m_cnt = 0;
    endtask

    task automatic model_step(input int stb, input int k, input int be, input int pc_hit);
        int lp, sp, hit;
        int n_db, n_run;
        lp  = (m_db == 1 && m_hold == LONG - 1) ? 1 : 0;
        sp  = (m_prev == 1 && m_db == 0 && m_hold < LONG) ? 1 : 0;
        hit = stb & be & pc_hit;
        n_db = m_db;
        n_run = 0;
        if (m_k2 != m_db) begin
            if (m_run + 1 == DEB) n_db = 1 - m_db;
            else n_run = m_run + 1;
        end
        m_prev = m_db;
        m_hold = (m_db == 1) ? m_hold + 1 : 0;
        m_db = n_db;
        m_run = n_run;
        m_k2 = m_k1;
        m_k1 = k;
        m_en = 0; m_rst = 0; m_halt = 0;
        case (m_mode)
            0: begin
                m_rst = 1; m_cnt = 0;
                if (m_rc + 1 == RSTC) begin m_mode = 1; m_rst = 0; m_rc = 0; end
                else m_rc = m_rc + 1;
            end
            1: begin
                if (hit == 1) begin m_mode = 4; m_halt = 1; end
                else if (lp == 1 || sp == 1) m_mode = 2;
                else if (stb == 1) begin m_en = 1; m_cnt = (m_cnt + 1) % 65536; end
            end
            2: begin
                if (sp == 1) begin m_mode = 3; m_en = 1; m_cnt = (m_cnt + 1) % 65536; end
                else if (lp == 1) m_mode = 1;
            end
            3: m_mode = 2;
            4: begin
                if (lp == 1) begin m_mode = 0; m_rst = 1; m_rc = 0; m_cnt = 0; end
                else m_halt = 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    initial begin
        int n, en_cnt, run_len, max_run, step_seen, bad, key_left;
        logic [21:0] act, exp;

        vecs[0] = '{1'b1, 1'b0, 32'h08, 1'b1, 3'd1, 1'b0, 16'd4};
        vecs[1] = '{1'b0, 1'b0, 32'h08, 1'b0, 3'd1, 1'b0, 16'd4};
        vecs[2] = '{1'b1, 1'b1, 32'h14, 1'b1, 3'd1, 1'b0, 16'd5};
        vecs[3] = '{1'b0, 1'b1, 32'h10, 1'b0, 3'd1, 1'b0, 16'd5};
        vecs[4] = '{1'b1, 1'b0, 32'h10, 1'b1, 3'd1, 1'b0, 16'd6};
        vecs[5] = '{1'b1, 1'b1, 32'h10, 1'b0, 3'd4, 1'b1, 16'd6};
        vecs[6] = '{1'b1, 1'b1, 32'h20, 1'b0, 3'd4, 1'b1, 16'd6};
        vecs[7] = '{1'b0, 1'b0, 32'h20, 1'b0, 3'd4, 1'b1, 16'd6};

        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0; strobe = 1'b0; key = 1'b0; brk_en = 1'b0;
        cpu_pc = 32'h0; brk_pc = 32'h10;
        repeat (3) tick();
        check("rst_state", state, 3'd0);
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_en", cpu_clk_en, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt", step_count, 16'h0);

        rst_n = 1'b1;
        n = 0;
        while (cpu_rst === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("hold_cycles", n, RSTC);
        check("hold_to_run", state, 3'd1);

        // Three strobes ten cycles apart: one single-cycle enable each.
        for (int i = 0; i < 3; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            check($sformatf("strobe%0d_en", i), cpu_clk_en, 1'b1);
            tick();
            check($sformatf("strobe%0d_width", i), cpu_clk_en, 1'b0);
            repeat (8) tick();
        end
        check("three_strobes_cnt", step_count, 16'd3);

        for (int i = 0; i < 8; i++) begin
            strobe = vecs[i].stb;
            brk_en = vecs[i].ben;
            cpu_pc = vecs[i].pc;
            tick();
            check($sformatf("vec%0d_en", i), cpu_clk_en, vecs[i].exp_en);
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halt);
            check($sformatf("vec%0d_cnt", i), step_count, vecs[i].exp_cnt);
        end
        strobe = 1'b0; brk_en = 1'b0; cpu_pc = 32'h0;

        key = 1'b1;
        repeat (10) tick();
        key = 1'b0;
        repeat (15) tick();
        check("halt_short_state", state, 3'd4);
        check("halt_short_halted", halted, 1'b1);

        key = 1'b1;
        wait_state("halt_long_state", 3'd0, 40, n);
        check("halt_long_latency", n, 26);
        check("halt_long_cpu_rst", cpu_rst, 1'b1);
        check("halt_long_cnt", step_count, 16'h0);
        check("halt_long_halted", halted, 1'b0);
        repeat (4) tick();
        key = 1'b0;
        repeat (20) tick();
        check("after_hold_run", state, 3'd1);

        key = 1'b1;
        repeat (10) tick();
        key = 1'b0;
        wait_state("run_short_state", 3'd2, 20, n);
        check("run_short_latency", n, 7);
        en_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            strobe = (i % 3 == 0) ? 1'b1 : 1'b0;
            tick();
            if (cpu_clk_en === 1'b1) en_cnt++;
        end
        strobe = 1'b0;
        check("pause_no_en", en_cnt, 0);
        check("pause_stays", state, 3'd2);

        en_cnt = 0; run_len = 0; max_run = 0; step_seen = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 25; i++) begin
                key = (i < 10) ? 1'b1 : 1'b0;
                tick();
                if (cpu_clk_en === 1'b1) begin
                    en_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (state === 3'd3) step_seen++;
            end
            check($sformatf("step%0d_back_pause", p), state, 3'd2);
        end
        check("steps_en_pulses", en_cnt, 2);
        check("steps_en_width", max_run, 1);
        check("steps_state_cycles", step_seen, 2);
        check("steps_cnt", step_count, 16'd2);

        key = 1'b1;
        wait_state("pause_long_state", 3'd1, 40, n);
        check("pause_long_latency", n, 26);
        repeat (4) tick();
        key = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== 3'd1) bad++;
        end
        check("long_release_quiet", bad, 0);

        bad = 0;
        for (int i = 0; i < 40; i++) begin
            key = ((i % 4) < 2) ? 1'b1 : 1'b0;
            tick();
            if (state !== 3'd1) bad++;
        end
        key = 1'b0;
        repeat (10) tick();
        if (state !== 3'd1) bad++;
        check("glitch_no_event", bad, 0);

        strobe = 1'b1;
        repeat (65533) tick();
        strobe = 1'b0;
        check("wrap_pre_cnt", step_count, 16'hFFFF);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("wrap_en", cpu_clk_en, 1'b1);
        check("wrap_cnt", step_count, 16'h0000);

        key = 1'b1;
        repeat (10) tick();
        key = 1'b0;
        wait_state("pre_step_pause", 3'd2, 20, n);
        key = 1'b1;
        repeat (10) tick();
        key = 1'b0;
        wait_state("in_step_state", 3'd3, 20, n);
        check("in_step_en", cpu_clk_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_state", state, 3'd0);
        check("abort_en", cpu_clk_en, 1'b0);
        check("abort_cpu_rst", cpu_rst, 1'b1);
        check("abort_halted", halted, 1'b0);
        check("abort_cnt", step_count, 16'h0);

        // Randomized run against the behavioural model.
        model_reset();
        key = 1'b0; strobe = 1'b0; brk_en = 1'b0; cpu_pc = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        key_left = 5;
        for (int c = 0; c < 4000; c++) begin
            if (key_left == 0) begin
                key = ~key;
                key_left = (key == 1'b1) ? int'($urandom_range(1, 35)) : int'($urandom_range(1, 30));
            end
            key_left--;
            strobe = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            brk_en = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            cpu_pc = 32'h8 + 32'($urandom_range(0, 3)) * 32'h4;
            model_step(int'(strobe), int'(key), int'(brk_en), (cpu_pc == brk_pc) ? 1 : 0);
            tick();
            act = {state, cpu_clk_en, cpu_rst, halted, step_count};
            exp = {3'(m_mode), 1'(m_en), 1'(m_rst), 1'(m_halt), 16'(m_cnt)};
            check($sformatf("rand_c%0d", c), 32'(act), 32'(exp));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
